keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 17 +
 rtl/keypad_scanner_sync2.sv | 21 ++
 rtl/keypad_scanner.sv | 78 +++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, internal scan codes, keypad lookup and FSM state encoding
package keypad_pkg;
    localparam logic [7:0] KEY_STAR = 8'd14;
    localparam logic [7:0] KEY_HASH = 8'd15;
    localparam logic [7:0] NONE     = 8'hFE;
    localparam logic [7:0] INVALID  = 8'hFF;
    // One nibble per {row, col}; row0/col0 ('1') sits in the low nibble
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic {IDLE, PRESSED} state_t;

    function automatic logic [7:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [63:0] map;
        map = KEY_MAP;
        return {4'd0, map[{r, c, 2'b00} +: 4]};
    endfunction
endpackage

// File: rtl/keypad_scanner_sync2.sv
// sync2: parameterized-width two-flop synchronizer, resets to all ones (idle pulled-up lines)
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             hwclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge hwclk) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan with full-scan debouncing and one-key-only acceptance
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [7:0] key,
    output logic       button_pressed
);
    logic [3:0]  row_s, hits;
    logic [2:0]  nhits;
    logic [1:0]  r_idx, col_idx;
    logic [15:0] dwell;
    logic [7:0]  acc, acc_next, cand, prev_cand, stab, stab_next, key_next;
    logic        dwell_end, scan_end, bp_next;
    state_t      state, state_next;

    sync2 #(.WIDTH(4)) u_sync (.hwclk(hwclk), .reset(reset), .d(row), .q(row_s));

    assign col       = ~(4'b0001 << col_idx);
    assign dwell_end = dwell == 16'(SCAN_DIV - 1);
    assign scan_end  = dwell_end && col_idx == 2'd3;

    always_comb begin
        hits      = ~row_s;
        nhits     = 3'($countones(hits));
        r_idx     = hits[0] ? 2'd0 : hits[1] ? 2'd1 : hits[2] ? 2'd2 : 2'd3;
        acc_next  = acc;
        // Any second closed key anywhere in the scan poisons the whole scan
        if (dwell_end && (nhits > 3'd1 || (nhits == 3'd1 && acc != NONE)))
            acc_next = INVALID;
        else if (dwell_end && nhits == 3'd1)
            acc_next = key_code(r_idx, col_idx);
        cand       = (acc_next == INVALID) ? NONE : acc_next;
        stab_next  = (cand != prev_cand) ? 8'd1 :
                     (stab >= 8'(DEBOUNCE_SCANS)) ? stab : stab + 8'd1;
        state_next = state;
        key_next   = key;
        bp_next    = button_pressed;
        if (scan_end && stab_next == 8'(DEBOUNCE_SCANS)) begin
            if (state == IDLE && cand != NONE) begin
                state_next = PRESSED;
                key_next   = cand;
                bp_next    = 1'b1;
            end else if (state == PRESSED && cand == NONE) begin
                state_next = IDLE;
                bp_next    = 1'b0;
            end
        end
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            dwell          <= '0;
            col_idx        <= '0;
            acc            <= NONE;
            prev_cand      <= NONE;
            stab           <= '0;
            state          <= IDLE;
            key            <= '0;
            button_pressed <= 1'b0;
        end else begin
            dwell          <= dwell_end ? '0 : dwell + 16'd1;
            col_idx        <= dwell_end ? col_idx + 2'd1 : col_idx;
            acc            <= scan_end ? NONE : acc_next;
            prev_cand      <= scan_end ? cand : prev_cand;
            stab           <= scan_end ? stab_next : stab;
            state          <= state_next;
            key            <= key_next;
            button_pressed <= bp_next;
        end
    end
endmodule
